// File: rtl/driver_bus_arbiter.sv
// driver_bus_arbiter: hands the shared LED-driver control bus (SCLK, LAT) between the
// hardware synchronizer path (gen_*) and the HPS bit-bang path (hps_*).
//
// Ownership changes only at a safe point. A safe point is a completed grayscale LAT, or
// a timeout when ARB_TIMEOUT_EN is defined. Every handover inserts SETTLE_CYCLES idle
// cycles in which SCLK and LAT are held low. After the HPS releases the bus, force_fc
// pulses once so that the synchronizer rewrites the driver function-control registers.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   defined   - WAIT_SAFE gives up after TIMEOUT_CYCLES cycles, hands over anyway and
//               sets the sticky timeout_seen flag.
//   undefined - WAIT_SAFE waits indefinitely. No wait counter is built and
//               timeout_seen is tied to 0.
//
// Ports:
//   clk, rst      system clock and synchronous active-high reset
//   hps_req       level, HPS wants the bus
//   hps_grant     level, HPS owns the bus
//   hps_SCLK/LAT  HPS bit-banged bus lines
//   gen_SCLK/LAT  synchronizer bus lines
//   safe_point    1-cycle pulse, GS frame latched and bus quiescent
//   SCLK, LAT     registered, muxed bus lines to the drivers
//   hps_override  high whenever the hardware path does not own the bus
//   force_fc      1-cycle pulse requesting a function-control rewrite
//   timeout_seen  sticky, a forced handover has occurred
module driver_bus_arbiter #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic hps_req,
  output logic hps_grant,
  input  logic hps_SCLK,
  input  logic hps_LAT,
  input  logic gen_SCLK,
  input  logic gen_LAT,
  input  logic safe_point,
  output logic SCLK,
  output logic LAT,
  output logic hps_override,
  output logic force_fc,
  output logic timeout_seen
);

  localparam logic [2:0] StHwOwn     = 3'd0;
  localparam logic [2:0] StWaitSafe  = 3'd1;
  localparam logic [2:0] StAcqSettle = 3'd2;
  localparam logic [2:0] StHpsOwn    = 3'd3;
  localparam logic [2:0] StRelSettle = 3'd4;
  localparam logic [2:0] StFcResync  = 3'd5;

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);

  if (SETTLE_CYCLES == 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("driver_bus_arbiter: need SETTLE_CYCLES >= 1 and TIMEOUT_CYCLES >= 2");
  end

  logic [2:0]         state_q, state_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
  logic               sclk_q, lat_q, sclk_d, lat_d;
  logic               hps_grant_q, hps_override_q, force_fc_q;
  logic               settle_done;

  assign settle_done = (settle_cnt_q == SettleW'(SETTLE_CYCLES - 1));

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TimeoutW-1:0] wait_cnt_q, wait_cnt_d;
  logic                timeout_hit;
  logic                timeout_seen_q;
`endif

  // Next-state logic. A dropped request always wins over a safe point or a timeout.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
`ifdef ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    timeout_hit  = 1'b0;
`endif
    case (state_q)
      StHwOwn: begin
        if (hps_req) begin
          state_d    = StWaitSafe;
`ifdef ARB_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      StWaitSafe: begin
        if (!hps_req) begin
          state_d = StHwOwn;
        end else if (safe_point) begin
          state_d      = StAcqSettle;
          settle_cnt_d = '0;
`ifdef ARB_TIMEOUT_EN
        end else if (wait_cnt_q == TimeoutW'(TIMEOUT_CYCLES - 1)) begin
          state_d      = StAcqSettle;
          settle_cnt_d = '0;
          timeout_hit  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TimeoutW'(1);
`endif
        end
      end
      StAcqSettle: begin
        if (!hps_req) begin
          state_d      = StRelSettle;
          settle_cnt_d = '0;
        end else if (settle_done) begin
          state_d = StHpsOwn;
        end else begin
          settle_cnt_d = settle_cnt_q + SettleW'(1);
        end
      end
      StHpsOwn: begin
        if (!hps_req) begin
          state_d      = StRelSettle;
          settle_cnt_d = '0;
        end
      end
      StRelSettle: begin
        // hps_req is deliberately not looked at until the bus is back in HW_OWN.
        if (settle_done) begin
          state_d = StFcResync;
        end else begin
          settle_cnt_d = settle_cnt_q + SettleW'(1);
        end
      end
      StFcResync: state_d = StHwOwn;
      default:    state_d = StHwOwn;
    endcase
  end

  // The bus source follows the current owner. The settle states drive the lines low.
  always_comb begin
    sclk_d = 1'b0;
    lat_d  = 1'b0;
    case (state_q)
      StHwOwn, StWaitSafe: begin
        sclk_d = gen_SCLK;
        lat_d  = gen_LAT;
      end
      StHpsOwn: begin
        sclk_d = hps_SCLK;
        lat_d  = hps_LAT;
      end
      default: begin
        sclk_d = 1'b0;
        lat_d  = 1'b0;
      end
    endcase
  end

  // Status outputs are decoded from state_d so that they track the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StHwOwn;
      settle_cnt_q   <= '0;
      sclk_q         <= 1'b0;
      lat_q          <= 1'b0;
      hps_grant_q    <= 1'b0;
      hps_override_q <= 1'b0;
      force_fc_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      sclk_q         <= sclk_d;
      lat_q          <= lat_d;
      hps_grant_q    <= (state_d == StHpsOwn);
      hps_override_q <= (state_d != StHwOwn);
      force_fc_q     <= (state_d == StFcResync);
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q     <= '0;
      timeout_seen_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (timeout_hit) begin
        timeout_seen_q <= 1'b1;
      end
    end
  end
  assign timeout_seen = timeout_seen_q;
`else
  assign timeout_seen = 1'b0;
`endif

  assign SCLK         = sclk_q;
  assign LAT          = lat_q;
  assign hps_grant    = hps_grant_q;
  assign hps_override = hps_override_q;
  assign force_fc     = force_fc_q;

endmodule

// File: tb/tb_driver_bus_arbiter.sv
// Bench for driver_bus_arbiter. It applies directed handover scenarios and then random
// request, safe-point and reset traffic. Every cycle the bench computes the expected
// outputs from an ownership model and queues them. A monitor compares the queued values
// against the outputs that the DUT presents after the following clock edge.
module tb_driver_bus_arbiter;

  localparam int Settle  = 4;
  localparam int Timeout = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hps_req = 1'b0;
  logic safe_point = 1'b0;
  logic hps_SCLK = 1'b0, hps_LAT = 1'b0, gen_SCLK = 1'b0, gen_LAT = 1'b0;
  logic hps_grant, SCLK, LAT, hps_override, force_fc, timeout_seen;

  always #5 clk = ~clk;

  driver_bus_arbiter #(
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Timeout)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .hps_req     (hps_req),
    .hps_grant   (hps_grant),
    .hps_SCLK    (hps_SCLK),
    .hps_LAT     (hps_LAT),
    .gen_SCLK    (gen_SCLK),
    .gen_LAT     (gen_LAT),
    .safe_point  (safe_point),
    .SCLK        (SCLK),
    .LAT         (LAT),
    .hps_override(hps_override),
    .force_fc    (force_fc),
    .timeout_seen(timeout_seen)
  );

  typedef struct packed {
    logic sclk;
    logic lat;
    logic grant;
    logic ovr;
    logic fc;
    logic ts;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Ownership model. At most one of the phases is active at any time.
  // If none is active, the hardware path owns the bus and no request is pending.
  bit m_waiting;   // request pending, hardware still drives the bus
  int m_waited;    // cycles already spent waiting
  int m_acq_left;  // idle cycles left before the HPS gets the bus
  bit m_hps;       // HPS owns the bus
  int m_rel_left;  // idle cycles left after the HPS gave the bus back
  bit m_resync;    // the one cycle in which the FC rewrite is requested
  bit m_ts;        // a forced handover has happened since reset
  bit req_r;

  task automatic model_step();
    exp_t e;
    bit   quiet;
    e = '0;
    if (rst) begin
      m_waiting  = 0;
      m_waited   = 0;
      m_acq_left = 0;
      m_hps      = 0;
      m_rel_left = 0;
      m_resync   = 0;
      m_ts       = 0;
    end else begin
      // The bus lines after this edge reflect the owner before this edge.
      quiet = (m_acq_left > 0) || (m_rel_left > 0) || m_resync;
      if (m_hps) begin
        e.sclk = hps_SCLK;
        e.lat  = hps_LAT;
      end else if (!quiet) begin
        e.sclk = gen_SCLK;
        e.lat  = gen_LAT;
      end

      if (m_resync) begin
        m_resync = 0;
      end else if (m_rel_left > 0) begin
        m_rel_left--;
        if (m_rel_left == 0) m_resync = 1;
      end else if (m_hps) begin
        if (!hps_req) begin
          m_hps      = 0;
          m_rel_left = Settle;
        end
      end else if (m_acq_left > 0) begin
        if (!hps_req) begin
          m_acq_left = 0;
          m_rel_left = Settle;
        end else begin
          m_acq_left--;
          if (m_acq_left == 0) m_hps = 1;
        end
      end else if (m_waiting) begin
        if (!hps_req) begin
          m_waiting = 0;
        end else if (safe_point) begin
          m_waiting  = 0;
          m_acq_left = Settle;
`ifdef ARB_TIMEOUT_EN
        end else if (m_waited + 1 >= Timeout) begin
          m_waiting  = 0;
          m_acq_left = Settle;
          m_ts       = 1;
`endif
        end else begin
          m_waited++;
        end
      end else if (hps_req) begin
        m_waiting = 1;
        m_waited  = 0;
      end

      e.grant = m_hps;
      e.ovr   = m_waiting || (m_acq_left > 0) || m_hps || (m_rel_left > 0) || m_resync;
      e.fc    = m_resync;
      e.ts    = m_ts;
    end
    exp_q.push_back(e);
  endtask

  // Drives one cycle of inputs on the falling edge and queues the expected outputs.
  task automatic cyc(input bit r, input bit req, input bit sp);
    @(negedge clk);
    rst        = r;
    hps_req    = req;
    safe_point = sp;
    gen_SCLK   = 1'($urandom_range(0, 1));
    gen_LAT    = 1'($urandom_range(0, 1));
    hps_SCLK   = 1'($urandom_range(0, 1));
    hps_LAT    = 1'($urandom_range(0, 1));
    model_step();
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: compares just after each rising edge, which is away from the input drive.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("SCLK", SCLK, e.sclk);
        chk("LAT", LAT, e.lat);
        chk("hps_grant", hps_grant, e.grant);
        chk("hps_override", hps_override, e.ovr);
        chk("force_fc", force_fc, e.fc);
        chk("timeout_seen", timeout_seen, e.ts);
      end
    end
  end

  initial begin
    repeat (3) cyc(1, 0, 0);
    // Idle: the bus follows gen_* and no status output is active.
    repeat (12) cyc(0, 0, 0);
    // Acquire on a safe point after 10 cycles of waiting, hold, then release.
    repeat (10) cyc(0, 1, 0);
    cyc(0, 1, 1);
    repeat (12) cyc(0, 1, 0);
    repeat (12) cyc(0, 0, 0);
    // No safe point: a timeout handover, or an indefinite wait without the feature.
    repeat (40) cyc(0, 1, 0);
    repeat (14) cyc(0, 0, 0);
    // A dropped request and a safe point in the same cycle: the drop wins.
    repeat (5) cyc(0, 1, 0);
    cyc(0, 0, 1);
    repeat (8) cyc(0, 0, 0);
    // The request drops during the acquire settle.
    repeat (3) cyc(0, 1, 0);
    cyc(0, 1, 1);
    repeat (2) cyc(0, 1, 0);
    repeat (12) cyc(0, 0, 0);
    // Reset while the HPS owns the bus.
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    repeat (8) cyc(0, 1, 0);
    cyc(1, 1, 0);
    repeat (8) cyc(0, 0, 0);
    // A request pulse during the release settle is ignored.
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    repeat (8) cyc(0, 1, 0);
    repeat (2) cyc(0, 0, 0);
    repeat (2) cyc(0, 1, 0);
    repeat (12) cyc(0, 0, 0);
    // Random traffic. Safe points also arrive outside WAIT_SAFE.
    req_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) req_r = !req_r;
      cyc(($urandom_range(0, 599) == 0), req_r, ($urandom_range(0, 9) == 0));
    end
    repeat (20) cyc(0, 0, 0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries never compared, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
